// File: rtl/seg_scanner.sv
// seg_scanner: eight-digit multiplexed seven-segment display scanner.
//
// Shows a 32-bit hex value on eight common-anode digits, one digit at a time.
// Before each digit is lit, all anodes are switched off for a short time so
// the old segment pattern does not ghost onto the next digit. A new value is
// held in a pending register and only becomes visible at a frame boundary,
// so a frame never shows a mix of old and new digits.
//
// Ports:
//   sysCLK     in   1  system clock
//   reset      in   1  asynchronous, active-low reset
//   load       in   1  strobe: capture value/dp_mask into the pending register
//   value      in  32  hex digits; digit i = value[4i+3:4i], shown on AN[i]
//   dp_mask    in   8  bit i lights the decimal point of digit i
//   blank_lz   in   1  level: suppress leading zeros when 1
//   Cx         out  8  segments, active-low; bit 7 = DP, bits 6:0 = g..a
//   AN         out  8  anodes, active-low; at most one bit low at a time
//   frame_done out  1  pulse on the last SHOW cycle of digit 7
module seg_scanner #(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLANK_CYC = 16
) (
  input  logic        sysCLK,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] value,
  input  logic [7:0]  dp_mask,
  input  logic        blank_lz,
  output logic [7:0]  Cx,
  output logic [7:0]  AN,
  output logic        frame_done
);

  localparam int MAX_CYC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [0:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    idx_reg, idx_next;
  logic [31:0]   active_reg, active_next;
  logic [7:0]    act_dp_reg, act_dp_next;
  logic [31:0]   pend_reg, pend_next;
  logic [7:0]    pend_dp_reg, pend_dp_next;
  logic          pend_valid_reg, pend_valid_next;
  logic [7:0]    an_reg, an_next;
  logic [7:0]    cx_reg, cx_next;
  logic          fd_reg, fd_next;

  logic          blank_end, show_end, wrap;
  logic [3:0]    digit;
  logic [7:0]    lz;

  function automatic logic [6:0] seg7(input logic [3:0] hex);
    logic [6:0] s;
    case (hex)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Digit i is a leading zero when every digit from 7 down to i is zero.
  // Digit 0 always shows, so a zero value still displays "0".
  assign lz[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_lz
      assign lz[gi] = blank_lz && (active_reg[31:4*gi] == '0);
    end
  endgenerate

  assign digit     = active_reg[{idx_reg, 2'b00} +: 4];
  assign blank_end = (state_reg == ST_BLANK) && (cnt_reg == BLANK_LAST);
  assign show_end  = (state_reg == ST_SHOW) && (cnt_reg == SHOW_LAST);
  assign wrap      = show_end && (idx_reg == 3'd7);

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg + 1'b1;
    idx_next        = idx_reg;
    active_next     = active_reg;
    act_dp_next     = act_dp_reg;
    pend_next       = pend_reg;
    pend_dp_next    = pend_dp_reg;
    pend_valid_next = pend_valid_reg;
    an_next         = an_reg;
    cx_next         = cx_reg;

    // AN/Cx are computed only on phase transitions and held in between, so
    // blank_lz and the active value are effectively sampled per digit.
    if (blank_end) begin
      state_next = ST_SHOW;
      cnt_next   = '0;
      an_next    = ~(8'b1 << idx_reg);
      cx_next    = {~act_dp_reg[idx_reg], lz[idx_reg] ? 7'h7F : seg7(digit)};
    end else if (show_end) begin
      state_next = ST_BLANK;
      cnt_next   = '0;
      idx_next   = idx_reg + 3'd1;
      an_next    = 8'hFF;
      cx_next    = 8'hFF;
    end

    // A load landing on the wrap cycle bypasses pending and goes live at once.
    if (wrap) begin
      if (load) begin
        active_next = value;
        act_dp_next = dp_mask;
      end else if (pend_valid_reg) begin
        active_next = pend_reg;
        act_dp_next = pend_dp_reg;
      end
      pend_valid_next = 1'b0;
    end else if (load) begin
      pend_next       = value;
      pend_dp_next    = dp_mask;
      pend_valid_next = 1'b1;
    end

    // Registered pulse: high while the scan sits in the wrap cycle.
    fd_next = (state_next == ST_SHOW) && (cnt_next == SHOW_LAST) && (idx_next == 3'd7);
  end

  always_ff @(posedge sysCLK or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_BLANK;
      cnt_reg        <= '0;
      idx_reg        <= 3'd0;
      active_reg     <= 32'h0;
      act_dp_reg     <= 8'h0;
      pend_reg       <= 32'h0;
      pend_dp_reg    <= 8'h0;
      pend_valid_reg <= 1'b0;
      an_reg         <= 8'hFF;
      cx_reg         <= 8'hFF;
      fd_reg         <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      active_reg     <= active_next;
      act_dp_reg     <= act_dp_next;
      pend_reg       <= pend_next;
      pend_dp_reg    <= pend_dp_next;
      pend_valid_reg <= pend_valid_next;
      an_reg         <= an_next;
      cx_reg         <= cx_next;
      fd_reg         <= fd_next;
    end
  end

  assign AN         = an_reg;
  assign Cx         = cx_reg;
  assign frame_done = fd_reg;

endmodule

// File: tb/tb_seg_scanner.sv
// tb_seg_scanner: directed self-checking bench for seg_scanner with
// SCAN_DIV=4, BLANK_CYC=2 (6-cycle digit period, 48-cycle frame).
// Outputs are sampled on the falling edge; the sample taken just before
// rising edge k is cycle k of the frame (tracked in pos).
module tb_seg_scanner;
  localparam int SD    = 4;
  localparam int BC    = 2;
  localparam int DIGP  = SD + BC;
  localparam int FRAME = 8 * DIGP;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [31:0] value = 32'h0;
  logic [7:0]  dp_mask = 8'h0;
  logic        blank_lz = 1'b0;
  logic [7:0]  Cx;
  logic [7:0]  AN;
  logic        frame_done;

  int checks = 0;
  int failures = 0;
  int pos = 0;

  seg_scanner #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .sysCLK(clk), .reset(reset), .load(load), .value(value),
    .dp_mask(dp_mask), .blank_lz(blank_lz), .Cx(Cx), .AN(AN),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    pos = (pos + 1) % FRAME;
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < FRAME && pos != p; i++) step();
  endtask

  task automatic do_load(input logic [31:0] v, input logic [7:0] m);
    value = v;
    dp_mask = m;
    load = 1'b1;
    $display("load value=%h dp=%h at pos %0d", v, m, pos);
    step();
    load = 1'b0;
  endtask

  // Checks one full frame starting at pos 0; exp holds {d7,...,d0} Cx bytes.
  task automatic check_frame(input string name, input logic [63:0] exp);
    logic [7:0] e, ea;
    wait_pos(0);
    for (int d = 0; d < 8; d++) begin
      wait_pos(d * DIGP);
      checks++;
      if (AN !== 8'hFF || Cx !== 8'hFF) begin
        failures++;
        $display("FAIL %s blank d%0d: AN=%h Cx=%h required AN=FF Cx=FF", name, d, AN, Cx);
      end
      wait_pos(d * DIGP + BC + 1);
      e = exp[8*d +: 8];
      ea = ~(8'b1 << d);
      checks++;
      if (AN !== ea || Cx !== e) begin
        failures++;
        $display("FAIL %s show d%0d: AN=%h Cx=%h required AN=%h Cx=%h", name, d, AN, Cx, ea, e);
      end
    end
    wait_pos(FRAME - 1);
    checks++;
    if (frame_done !== 1'b1) begin
      failures++;
      $display("FAIL %s frame_done: got %b required 1", name, frame_done);
    end
    $display("frame %s checked", name);
  endtask

  task automatic test_reset();
    logic [7:0] ea, ec;
    repeat (3) @(negedge clk);
    checks++;
    if (AN !== 8'hFF || Cx !== 8'hFF || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: AN=%h Cx=%h fd=%b required FF FF 0", AN, Cx, frame_done);
    end
    reset = 1'b1;
    pos = 0;
    for (int k = 0; k < FRAME; k++) begin
      if ((k % DIGP) < BC) begin
        ea = 8'hFF; ec = 8'hFF;
      end else begin
        ea = ~(8'b1 << (k / DIGP)); ec = 8'hC0;
      end
      checks++;
      if (AN !== ea || Cx !== ec || frame_done !== (k == FRAME - 1)) begin
        failures++;
        $display("FAIL first_frame cyc%0d: AN=%h Cx=%h fd=%b required AN=%h Cx=%h fd=%b",
                 k, AN, Cx, frame_done, ea, ec, (k == FRAME - 1));
      end
      if (k != FRAME - 1) step();
    end
    $display("first frame after reset checked");
  endtask

  task automatic test_hex_decode();
    wait_pos(10);
    do_load(32'hFEDC_BA98, 8'h00);
    check_frame("hex_hi", {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80});
    wait_pos(10);
    do_load(32'h7654_3210, 8'h00);
    check_frame("hex_lo", {8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0});
  endtask

  task automatic test_tear_free();
    logic [31:0] old_cx;
    old_cx = {8'hF8, 8'h82, 8'h92, 8'h99};
    wait_pos(3 * DIGP + BC + 1);
    do_load(32'h1111_1111, 8'h00);
    for (int d = 4; d < 8; d++) begin
      wait_pos(d * DIGP + BC + 1);
      checks++;
      if (Cx !== old_cx[8*(d-4) +: 8]) begin
        failures++;
        $display("FAIL tear_old d%0d: Cx=%h required %h", d, Cx, old_cx[8*(d-4) +: 8]);
      end
    end
    check_frame("tear_new", {8{8'hF9}});
    wait_pos(5);
    do_load(32'h2222_2222, 8'h00);
    wait_pos(20);
    do_load(32'h3333_3333, 8'h00);
    check_frame("last_load_wins", {8{8'hB0}});
  endtask

  task automatic test_wrap_load();
    wait_pos(FRAME - 1);
    checks++;
    if (frame_done !== 1'b1) begin
      failures++;
      $display("FAIL wrap_fd: got %b required 1", frame_done);
    end
    do_load(32'h0000_0005, 8'h00);
    checks++;
    if (dut.pend_valid_reg !== 1'b0) begin
      failures++;
      $display("FAIL wrap_pend_valid: got %b required 0", dut.pend_valid_reg);
    end
    check_frame("wrap_load", {{7{8'hC0}}, 8'h92});
    check_frame("wrap_load_hold", {{7{8'hC0}}, 8'h92});
  endtask

  task automatic test_lz_dp();
    blank_lz = 1'b1;
    wait_pos(10);
    do_load(32'h0000_0A00, 8'h81);
    check_frame("lz_dp", {8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h88, 8'hC0, 8'h40});
    wait_pos(10);
    do_load(32'h0000_0000, 8'h81);
    check_frame("lz_zero", {8'h7F, {6{8'hFF}}, 8'h40});
  endtask

  task automatic test_async_reset();
    blank_lz = 1'b0;
    wait_pos(10);
    do_load(32'h1234_5678, 8'hFF);
    wait_pos(5 * DIGP + BC + 1);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (AN !== 8'hFF || Cx !== 8'hFF || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: AN=%h Cx=%h fd=%b required FF FF 0", AN, Cx, frame_done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    pos = 0;
    check_frame("after_reset", {8{8'hC0}});
    check_frame("pending_lost", {8{8'hC0}});
  endtask

  initial begin
    test_reset();
    test_hex_decode();
    test_tear_free();
    test_wrap_load();
    test_lz_dp();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
